input_debouncer: RTL

//   Conditions a raw asynchronous level (button, bouncing test stimulus) into a

---
 rtl/input_debouncer.sv | 76 +++++++
 1 files changed

// File: rtl/input_debouncer.sv
// input_debouncer: two-flop synchronizer followed by a stability counter.
// dout follows din only after STABLE_CYCLES agreeing samples; rise/fall strobe.
`timescale 1ns/1ps
module input_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  if (STABLE_CYCLES < 1 ||
      longint'(STABLE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_param
    $error("input_debouncer: STABLE_CYCLES out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  logic             cnt_nx;
  logic             take;

  // only the second flop feeds the qualifier; q1 may be metastable
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
    end
  end

  always_comb begin
    cnt_nx = 1'b0;
    take   = 1'b0;
    if (sync_q2 != dout) begin
      if (cnt == LAST) take = 1'b1;
      else cnt_nx = 1'b1;
    end
  end

  // any sample that agrees with dout drops cnt back to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      dout <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (take) begin
        cnt  <= '0;
        dout <= sync_q2;
        rise <= sync_q2;
        fall <= ~sync_q2;
      end else if (cnt_nx) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

  assign busy = (sync_q2 != dout);

endmodule
